mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: byte-address width; storage is 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: request-capture to ready, in cycles; legal range 1..15.
REQ-003 SHALL have port clk  in  1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port memRead  in  1: load request.
REQ-006 SHALL have port memWrite  in  1: store request.
REQ-007 SHALL have port memMode  in  3: bits [1:0] give the size (00 byte, 01 half, 10 word, 11 illegal); bit [2] set means an unsigned load.
REQ-008 SHALL have port address  in  ADDR_WIDTH: byte address.
REQ-009 SHALL have port dataIn  in  32: store data, right-aligned.
REQ-010 SHALL have port dataOut  out  32: load data, right-aligned and extended.
REQ-011 SHALL have port ready  out  1: one-cycle completion strobe.
REQ-012 SHALL have port err  out  1: error flag, valid only while ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 IDLE with memRead|memWrite=1 at a rising edge SHALL capture memRead, memWrite, memMode, address and dataIn, load the counter with LATENCY-1, and go to WAIT.
REQ-015 WAIT SHALL go to RESP when the counter is 0; otherwise it SHALL decrement the counter.
REQ-016 RESP SHALL last exactly one cycle with ready=1 and SHALL then return to IDLE; a request is sampled again only in IDLE.
REQ-017 Timing: for a request captured at edge N, ready SHALL be 1 between edges N+LATENCY and N+LATENCY+1.
REQ-018 Inputs SHALL be ignored in WAIT and RESP; the initiator holds its request until it sees ready.
REQ-019 A store SHALL commit to storage on the WAIT->RESP edge, updating only the addressed bytes (byte lane address[1:0]; half lane address[1]).
REQ-020 A load SHALL register dataOut on the WAIT->RESP edge.
REQ-021 Load extension: byte and half loads SHALL be sign-extended when memMode[2]=0 and zero-extended when memMode[2]=1.
REQ-022 dataOut SHALL hold its last load value until the next successful load completes; stores and errors SHALL leave it unchanged.
REQ-023 A request with memRead=memWrite=1, or with size 11, SHALL complete with the normal latency, err=1, no storage change and dataOut unchanged.
REQ-024 The word index SHALL be address[ADDR_WIDTH-1:2]; the address SHALL never wrap beyond storage, because the width is exact.
REQ-025 Storage SHALL NOT be reset; its contents SHALL be zero at simulation start.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, ready=0, err=0, dataOut=32'h0, captured request cleared.
REQ-027 Reset asserted during WAIT SHALL abort the access; a pending store SHALL NOT commit, and no ready pulse SHALL follow.
REQ-028 The first request SHALL be captured no earlier than the first rising edge after rst deasserts.

Configuration
REQ-029 Macro MEM_RESPONDER_MISALIGN_TRAP_EN, when defined: a half access with address[0]=1, or a word access with address[1:0]!=0, SHALL complete with err=1, no store and dataOut unchanged.
REQ-030 Without MEM_RESPONDER_MISALIGN_TRAP_EN: misaligned accesses SHALL silently ignore the low address bits (half uses address[1], word uses neither), and err SHALL be 0.

Verification
REQ-031 Scenario: LATENCY=2; store word 32'hDEADBEEF to 0x010, then load word 0x010 -> each ready exactly 2 cycles after capture; load dataOut=32'hDEADBEEF, err=0.
REQ-032 Scenario: store byte 8'h80 to 0x013 over word 0 -> load byte signed 0x013 gives 32'hFFFFFF80; load byte unsigned gives 32'h00000080; word 0x010 reads 32'h80ADBEEF.
REQ-033 Scenario: store half 16'h1234 to 0x012 -> load half signed 0x012 gives 32'h00001234; word 0x010 reads 32'h1234BEEF.
REQ-034 Scenario: memRead=memWrite=1, then separately memMode=3'b011 -> ready after LATENCY cycles with err=1; storage and dataOut unchanged.
REQ-035 Scenario: word load from 0x012 -> with the macro, err=1; without it, data from word 0x010 and err=0.
REQ-036 Scenario: capture a store of 32'h0 to 0x010, pulse rst one cycle later -> no ready pulse, dataOut=0, and a later load of 0x010 returns the pre-reset contents.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-ported data-memory responder with a fixed request-to-ready latency.
// A load or store request is captured in IDLE, held for LATENCY cycles, and
// completed with a one-cycle ready strobe. Stores commit and loads register
// their result on the WAIT->RESP edge. Byte and half accesses select their lane
// from the low address bits. Loads are sign- or zero-extended.
//
// Parameters
//   ADDR_WIDTH  byte-address width; storage is 2^(ADDR_WIDTH-2) 32-bit words
//   LATENCY     capture-to-ready distance in cycles, 1..15
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   memRead   in   load request
//   memWrite  in   store request
//   memMode   in   [1:0] size (00 byte, 01 half, 10 word, 11 illegal),
//                  [2] unsigned load
//   address   in   byte address
//   dataIn    in   store data, right-aligned
//   dataOut   out  last successful load data, right-aligned and extended
//   ready     out  one-cycle completion strobe
//   err       out  request error, meaningful only while ready=1
//
// Configuration macro
//   MEM_RESPONDER_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses
//                                   complete with err=1 and have no effect.
//                                   When undefined, the offending low address
//                                   bits are ignored.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            memMode,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           dataIn,
    output logic [31:0]           dataOut,
    output logic                  ready,
    output logic                  err
);

    localparam int unsigned Depth   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // -------------------------------------------------------------------------
    // State and captured request
    // -------------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [2:0]              mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             dout_q, dout_d;

    // Storage has no reset; contents survive rst.
    logic [31:0]             mem_q [Depth];

    // -------------------------------------------------------------------------
    // Decode of the captured request
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [31:0]             rdata_word;
    logic                    misalign;
    logic                    req_err;
    logic                    finish;
    logic                    store_commit;
    logic                    load_commit;

    assign word_idx   = addr_q[ADDR_WIDTH-1:2];
    assign rdata_word = mem_q[word_idx];

`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    assign misalign = ((mode_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((mode_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (rd_q & wr_q) | (mode_q[1:0] == 2'b11) | misalign;

    // Last WAIT cycle: the upcoming edge is the WAIT->RESP edge.
    assign finish = (state_q == StWait) && (cnt_q == 4'd0);

    // rst is also checked here so a reset that coincides with the commit edge
    // can never let a store through.
    assign store_commit = finish & wr_q & ~req_err & ~rst;
    assign load_commit  = finish & rd_q & ~req_err;

    // -------------------------------------------------------------------------
    // Store lane steering
    // -------------------------------------------------------------------------
    logic [3:0]  be;
    logic [31:0] wdata_lane;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata_q;
        case (mode_q[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                // Half lane comes from address[1] only; address[0] is ignored
                // here (and trapped earlier when the trap macro is enabled).
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be         = 4'b1111;
                wdata_lane = wdata_q;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load lane selection and extension
    // -------------------------------------------------------------------------
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sext;
    logic [31:0] load_data;

    assign rd_byte = rdata_word[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = addr_q[1] ? rdata_word[31:16] : rdata_word[15:0];
    assign sext    = ~mode_q[2];

    always_comb begin
        load_data = rdata_word;
        case (mode_q[1:0])
            2'b00:   load_data = {{24{sext & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{sext & rd_half[15]}}, rd_half};
            default: load_data = rdata_word;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mode_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and captured-request update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;

        case (state_q)
            StIdle: begin
                if (memRead | memWrite) begin
                    rd_d    = memRead;
                    wr_d    = memWrite;
                    mode_d  = memMode;
                    addr_d  = address;
                    wdata_d = dataIn;
                    cnt_d   = CntLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Inputs are deliberately not looked at here; the initiator
                // keeps its request up until ready.
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (load_commit) begin
                        dout_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready   = (state_q == StResp);
    assign err     = ready & req_err;
    assign dataOut = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int unsigned AW  = 12;
    localparam int          LAT = 2;

`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          memRead;
    logic          memWrite;
    logic [2:0]    memMode;
    logic [AW-1:0] address;
    logic [31:0]   dataIn;
    logic [31:0]   dataOut;
    logic          ready;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mode;
        logic [11:0] addr;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic        exp_err;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int          obs_lat;
    logic [31:0] obs_data;
    logic        obs_err;
    logic        obs_after;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memRead (memRead),
        .memWrite(memWrite),
        .memMode (memMode),
        .address (address),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .ready   (ready),
        .err     (err)
    );

    // Drive one request, record what the DUT returns. After capture the
    // non-handshake inputs are scrambled: the DUT must ignore them.
    task automatic issue(input req_t r);
        exp_t e;
        e.data = r.exp_data;
        e.err  = r.exp_err;
        sb.push_back(e);
        @(negedge clk);
        memRead  = r.rd;
        memWrite = r.wr;
        memMode  = r.mode;
        address  = r.addr;
        dataIn   = r.din;
        @(posedge clk);
        #1;
        address = r.addr ^ 12'h024;
        dataIn  = ~r.din;
        memMode = r.mode ^ 3'b101;
        obs_lat = -1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                obs_lat = c;
                break;
            end
        end
        obs_data = dataOut;
        obs_err  = err;
        memRead  = 1'b0;
        memWrite = 1'b0;
        @(posedge clk);
        #1;
        obs_after = ready;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memMode  = 3'b000;
        address  = '0;
        dataIn   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, want 0", ready);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b, want 0", err);
        end
        n_checks++;
        if (dataOut !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dataOut: got %h, want 00000000", dataOut);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle_ready: got %b, want 0", ready);
        end
    endtask

    task automatic test_word();
        req_t t[2] = '{
            '{1'b0, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0},
            '{1'b1, 1'b0, 3'b010, 12'h010, 32'h00000000, 32'hDEADBEEF, 1'b0}
        };
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            e = sb.pop_front();
            n_checks += 4;
            if (obs_lat != LAT) begin
                n_fail++;
                $display("FAIL word[%0d] latency: got %0d, want %0d", i, obs_lat, LAT);
            end
            if (obs_data !== e.data) begin
                n_fail++;
                $display("FAIL word[%0d] dataOut: got %h, want %h", i, obs_data, e.data);
            end
            if (obs_err !== e.err) begin
                n_fail++;
                $display("FAIL word[%0d] err: got %b, want %b", i, obs_err, e.err);
            end
            if (obs_after !== 1'b0) begin
                n_fail++;
                $display("FAIL word[%0d] ready_one_cycle: got %b, want 0", i, obs_after);
            end
        end
    endtask

    task automatic test_byte();
        req_t t[6] = '{
            '{1'b0, 1'b1, 3'b000, 12'h013, 32'h5A5A5A80, 32'hDEADBEEF, 1'b0},
            '{1'b1, 1'b0, 3'b000, 12'h013, 32'h00000000, 32'hFFFFFF80, 1'b0},
            '{1'b1, 1'b0, 3'b100, 12'h013, 32'h00000000, 32'h00000080, 1'b0},
            '{1'b1, 1'b0, 3'b010, 12'h010, 32'h00000000, 32'h80ADBEEF, 1'b0},
            '{1'b1, 1'b0, 3'b100, 12'h010, 32'h00000000, 32'h000000EF, 1'b0},
            '{1'b1, 1'b0, 3'b000, 12'h011, 32'h00000000, 32'hFFFFFFBE, 1'b0}
        };
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (obs_lat != LAT) begin
                n_fail++;
                $display("FAIL byte[%0d] latency: got %0d, want %0d", i, obs_lat, LAT);
            end
            if (obs_data !== e.data) begin
                n_fail++;
                $display("FAIL byte[%0d] dataOut: got %h, want %h", i, obs_data, e.data);
            end
            if (obs_err !== e.err) begin
                n_fail++;
                $display("FAIL byte[%0d] err: got %b, want %b", i, obs_err, e.err);
            end
        end
    endtask

    task automatic test_half();
        req_t t[5] = '{
            '{1'b0, 1'b1, 3'b001, 12'h012, 32'hA5A51234, 32'hFFFFFFBE, 1'b0},
            '{1'b1, 1'b0, 3'b001, 12'h012, 32'h00000000, 32'h00001234, 1'b0},
            '{1'b1, 1'b0, 3'b001, 12'h010, 32'h00000000, 32'hFFFFBEEF, 1'b0},
            '{1'b1, 1'b0, 3'b101, 12'h010, 32'h00000000, 32'h0000BEEF, 1'b0},
            '{1'b1, 1'b0, 3'b010, 12'h010, 32'h00000000, 32'h1234BEEF, 1'b0}
        };
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (obs_lat != LAT) begin
                n_fail++;
                $display("FAIL half[%0d] latency: got %0d, want %0d", i, obs_lat, LAT);
            end
            if (obs_data !== e.data) begin
                n_fail++;
                $display("FAIL half[%0d] dataOut: got %h, want %h", i, obs_data, e.data);
            end
            if (obs_err !== e.err) begin
                n_fail++;
                $display("FAIL half[%0d] err: got %b, want %b", i, obs_err, e.err);
            end
        end
    endtask

    task automatic test_error();
        req_t t[6] = '{
            '{1'b0, 1'b1, 3'b010, 12'h020, 32'hCAFEF00D, 32'h1234BEEF, 1'b0},
            '{1'b1, 1'b0, 3'b010, 12'h020, 32'h00000000, 32'hCAFEF00D, 1'b0},
            '{1'b1, 1'b1, 3'b010, 12'h010, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b1},
            '{1'b0, 1'b1, 3'b011, 12'h010, 32'h00000000, 32'hCAFEF00D, 1'b1},
            '{1'b1, 1'b0, 3'b011, 12'h010, 32'h00000000, 32'hCAFEF00D, 1'b1},
            '{1'b1, 1'b0, 3'b010, 12'h010, 32'h00000000, 32'h1234BEEF, 1'b0}
        };
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            e = sb.pop_front();
            n_checks += 4;
            if (obs_lat != LAT) begin
                n_fail++;
                $display("FAIL error[%0d] latency: got %0d, want %0d", i, obs_lat, LAT);
            end
            if (obs_data !== e.data) begin
                n_fail++;
                $display("FAIL error[%0d] dataOut: got %h, want %h", i, obs_data, e.data);
            end
            if (obs_err !== e.err) begin
                n_fail++;
                $display("FAIL error[%0d] err: got %b, want %b", i, obs_err, e.err);
            end
            if (obs_after !== 1'b0) begin
                n_fail++;
                $display("FAIL error[%0d] ready_one_cycle: got %b, want 0", i, obs_after);
            end
        end
    endtask

    task automatic test_misalign();
        req_t t[5] = '{
            '{1'b1, 1'b0, 3'b010, 12'h020, 32'h00000000, 32'hCAFEF00D, 1'b0},
            '{1'b1, 1'b0, 3'b010, 12'h012, 32'h00000000,
              TRAP ? 32'hCAFEF00D : 32'h1234BEEF, TRAP},
            '{1'b1, 1'b0, 3'b101, 12'h013, 32'h00000000,
              TRAP ? 32'hCAFEF00D : 32'h00001234, TRAP},
            '{1'b0, 1'b1, 3'b001, 12'h011, 32'h00005678,
              TRAP ? 32'hCAFEF00D : 32'h00001234, TRAP},
            '{1'b1, 1'b0, 3'b010, 12'h010, 32'h00000000,
              TRAP ? 32'h1234BEEF : 32'h12345678, 1'b0}
        };
        exp_t e;
        foreach (t[i]) begin
            issue(t[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (obs_lat != LAT) begin
                n_fail++;
                $display("FAIL misalign[%0d] latency: got %0d, want %0d", i, obs_lat, LAT);
            end
            if (obs_data !== e.data) begin
                n_fail++;
                $display("FAIL misalign[%0d] dataOut: got %h, want %h", i, obs_data, e.data);
            end
            if (obs_err !== e.err) begin
                n_fail++;
                $display("FAIL misalign[%0d] err: got %b, want %b", i, obs_err, e.err);
            end
        end
    endtask

    task automatic test_reset_abort();
        req_t        ld;
        exp_t        e;
        logic [31:0] pre = TRAP ? 32'h1234BEEF : 32'h12345678;
        int          seen = 0;
        @(negedge clk);
        memRead  = 1'b0;
        memWrite = 1'b1;
        memMode  = 3'b010;
        address  = 12'h010;
        dataIn   = 32'h00000000;
        @(posedge clk);   // capture edge
        #1;
        @(posedge clk);   // one cycle later, still in WAIT
        #1;
        rst      = 1'b1;
        memWrite = 1'b0;
        #1;
        n_checks++;
        if (dataOut !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_async_dataOut: got %h, want 00000000", dataOut);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ready === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_ready: got %0d ready cycles, want 0", seen);
        end
        n_checks++;
        if (dataOut !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_dataOut: got %h, want 00000000", dataOut);
        end
        ld = '{1'b1, 1'b0, 3'b010, 12'h010, 32'h00000000, pre, 1'b0};
        issue(ld);
        e = sb.pop_front();
        n_checks += 3;
        if (obs_lat != LAT) begin
            n_fail++;
            $display("FAIL abort_reload latency: got %0d, want %0d", obs_lat, LAT);
        end
        if (obs_data !== e.data) begin
            n_fail++;
            $display("FAIL abort_reload dataOut: got %h, want %h", obs_data, e.data);
        end
        if (obs_err !== e.err) begin
            n_fail++;
            $display("FAIL abort_reload err: got %b, want %b", obs_err, e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_error();
        test_misalign();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
